// File: rtl/acumulador_muestras.sv
// Block accumulator: sums N signed samples per block, emits 64-bit and scaled 32-bit results, M blocks per run.
// Define ACUM_SATURACION_32_EN to saturate result_32 instead of truncating it.
`timescale 1ns/1ps
module acumulador_muestras #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic              data_in_ready,
    input  logic [31:0]       n_muestras,
    input  logic [31:0]       n_bloques,
    input  logic [5:0]        shift,
    output logic [63:0]       result_64,
    output logic              result_64_valid,
    output logic [31:0]       result_32,
    output logic              result_32_valid,
    output logic              calculo_finalizado,
    output logic [31:0]       bloques_completos
);

    typedef enum logic [1:0] {IDLE, ACUM, EMIT, DONE} state_t;

    state_t             state_q, state_d;
    logic signed [63:0] sum_q, sum_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        n_q, n_d;
    logic [31:0]        m_q, m_d;
    logic [5:0]         shift_q, shift_d;
    logic [31:0]        bloques_q, bloques_d;
    logic [63:0]        result_64_q, result_64_d;
    logic [31:0]        result_32_q, result_32_d;

    logic               accept;
    logic signed [63:0] sample_ext;
    logic signed [63:0] sum_acc;
    logic [31:0]        scaled;

    // Gating with reset keeps a strobe or handshake from escaping in the cycle reset is applied.
    assign data_in_ready      = (state_q == ACUM) && enable && !reset;
    assign result_64_valid    = (state_q == EMIT) && !reset;
    assign result_32_valid    = (state_q == EMIT) && !reset;
    assign calculo_finalizado = (state_q == DONE);
    assign bloques_completos  = bloques_q;
    assign result_64          = result_64_q;
    assign result_32          = result_32_q;

    assign accept     = data_in_ready && data_in_valid;
    assign sample_ext = 64'($signed(data_in));
    assign sum_acc    = sum_q + sample_ext;

`ifdef ACUM_SATURACION_32_EN
    logic signed [63:0] sum_shifted;
    assign sum_shifted = sum_acc >>> shift_q;

    // In range only when bits 63..31 are all copies of the sign.
    always_comb begin
        scaled = sum_shifted[31:0];
        if (sum_shifted[63] && !(&sum_shifted[62:31])) begin
            scaled = 32'h8000_0000;
        end else if (!sum_shifted[63] && (|sum_shifted[62:31])) begin
            scaled = 32'h7FFF_FFFF;
        end
    end
`else
    assign scaled = 32'(sum_acc >>> shift_q);
`endif

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        count_d     = count_q;
        n_d         = n_q;
        m_d         = m_q;
        shift_d     = shift_q;
        bloques_d   = bloques_q;
        result_64_d = result_64_q;
        result_32_d = result_32_q;
        case (state_q)
            IDLE: begin
                if (enable && (n_muestras != 32'd0) && (n_bloques != 32'd0)) begin
                    n_d       = n_muestras;
                    m_d       = n_bloques;
                    shift_d   = shift;
                    sum_d     = '0;
                    count_d   = '0;
                    bloques_d = '0;
                    state_d   = ACUM;
                end
            end
            ACUM: begin
                if (!enable) begin
                    sum_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                end else if (accept) begin
                    sum_d   = sum_acc;
                    count_d = count_q + 32'd1;
                    // Results are captured here so they are on the outputs during the EMIT cycle.
                    if (count_q == n_q - 32'd1) begin
                        result_64_d = sum_acc;
                        result_32_d = scaled;
                        bloques_d   = bloques_q + 32'd1;
                        state_d     = EMIT;
                    end
                end
            end
            EMIT: begin
                sum_d   = '0;
                count_d = '0;
                if (!enable) begin
                    state_d = IDLE;
                end else if (bloques_q == m_q) begin
                    state_d = DONE;
                end else begin
                    state_d = ACUM;
                end
            end
            DONE: begin
                if (!enable) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sum_q       <= '0;
            count_q     <= '0;
            n_q         <= '0;
            m_q         <= '0;
            shift_q     <= '0;
            bloques_q   <= '0;
            result_64_q <= '0;
            result_32_q <= '0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            n_q         <= n_d;
            m_q         <= m_d;
            shift_q     <= shift_d;
            bloques_q   <= bloques_d;
            result_64_q <= result_64_d;
            result_32_q <= result_32_d;
        end
    end

endmodule

// File: tb/tb_acumulador_muestras.sv
// Self-checking bench for acumulador_muestras: directed scenarios plus randomized runs against a block-sum model.
`timescale 1ns/1ps
module tb_acumulador_muestras;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [31:0] n_muestras;
    logic [31:0] n_bloques;
    logic [5:0]  shift;
    logic [63:0] result_64;
    logic        result_64_valid;
    logic [31:0] result_32;
    logic        result_32_valid;
    logic        calculo_finalizado;
    logic [31:0] bloques_completos;

    int n_cmp = 0;
    int n_mis = 0;
    int samp_q[$];

    always #5 clk = ~clk;

    acumulador_muestras #(.DATA_W(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .data_in            (data_in),
        .data_in_valid      (data_in_valid),
        .data_in_ready      (data_in_ready),
        .n_muestras         (n_muestras),
        .n_bloques          (n_bloques),
        .shift              (shift),
        .result_64          (result_64),
        .result_64_valid    (result_64_valid),
        .result_32          (result_32),
        .result_32_valid    (result_32_valid),
        .calculo_finalizado (calculo_finalizado),
        .bloques_completos  (bloques_completos)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, required end before 500us");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference scaling: arithmetic shift of the block sum, then truncate or clamp to 32 bits.
    function automatic logic [31:0] model32(input longint s, input int sh);
        longint t;
        t = s >>> sh;
`ifdef ACUM_SATURACION_32_EN
        if (t > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (t < -64'sh8000_0000) return 32'h8000_0000;
`endif
        return t[31:0];
    endfunction

    // Full run of m blocks of n samples from samp_q, with random valid gaps (gap = percent idle).
    task automatic run_blocks(input string tag, input int n, input int m, input int sh, input int gap);
        longint      exp64[$];
        logic [31:0] exp32[$];
        logic [63:0] o64[$];
        logic [31:0] o32[$];
        logic [31:0] ob[$];
        int          sc[$];
        int          ac[$];
        int          idx, acc, cyc, done_cyc, total;
        bit          seen_done, prev_strobe;
        longint      s;
        total = n * m;
        for (int b = 0; b < m; b++) begin
            s = 0;
            for (int k = 0; k < n; k++) s += longint'(samp_q[b*n+k]);
            exp64.push_back(s);
            exp32.push_back(model32(s, sh));
        end
        enable = 1'b1; n_muestras = n; n_bloques = m; shift = 6'(sh); data_in_valid = 1'b0;
        idx = 0; acc = 0; cyc = 0; done_cyc = 0; seen_done = 0; prev_strobe = 0;
        while (!seen_done && cyc < 2000) begin
            @(negedge clk);
            if (prev_strobe) ob.push_back(bloques_completos);
            prev_strobe = result_64_valid;
            if (result_64_valid) begin o64.push_back(result_64); sc.push_back(cyc); end
            if (result_32_valid) o32.push_back(result_32);
            if (data_in_valid && data_in_ready) begin
                acc++; idx++;
                if (acc % n == 0) ac.push_back(cyc);
            end
            if (calculo_finalizado) begin seen_done = 1; done_cyc = cyc; end
            @(posedge clk); #1; cyc++;
            if (cyc == 1) begin
                n_muestras = $urandom; n_bloques = $urandom; shift = 6'($urandom);
            end
            if (idx < total && $urandom_range(99) >= gap) begin
                data_in_valid = 1'b1; data_in = samp_q[idx];
            end else begin
                data_in_valid = 1'b0; data_in = $urandom;
            end
        end
        chk({tag, "_done_reached"}, 64'(seen_done), 64'd1);
        chk({tag, "_n_strobe64"}, 64'(o64.size()), 64'(m));
        chk({tag, "_n_strobe32"}, 64'(o32.size()), 64'(m));
        for (int i = 0; i < m && i < o64.size(); i++) begin
            chk($sformatf("%s_r64_%0d", tag, i), o64[i], exp64[i]);
            if (i < ac.size()) chk($sformatf("%s_lat_%0d", tag, i), 64'(sc[i] - ac[i]), 64'd1);
        end
        for (int i = 0; i < m && i < o32.size(); i++)
            chk($sformatf("%s_r32_%0d", tag, i), 64'(o32[i]), 64'(exp32[i]));
        for (int i = 0; i < ob.size(); i++)
            chk($sformatf("%s_bloques_%0d", tag, i), 64'(ob[i]), 64'(i + 1));
        if (o64.size() > 0) chk({tag, "_done_lat"}, 64'(done_cyc - sc[o64.size()-1]), 64'd1);
        enable = 1'b0; data_in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_done_hold"}, 64'(calculo_finalizado), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_done_clear"}, 64'(calculo_finalizado), 64'd0);
        chk({tag, "_hold64"}, result_64, exp64[m-1]);
        chk({tag, "_hold32"}, 64'(result_32), 64'(exp32[m-1]));
        $display("run %s: N=%0d M=%0d shift=%0d strobes=%0d cycles=%0d", tag, n, m, sh, o64.size(), cyc);
        @(posedge clk); #1;
    endtask

    // Starts a run, feeds k samples back-to-back, then drops enable and watches for stray activity.
    task automatic abort_run(input string tag, input int n, input int m, input int k);
        int acc, cyc, strobes;
        bit ready_seen;
        enable = 1'b1; n_muestras = n; n_bloques = m; shift = 6'd0; data_in_valid = 1'b0;
        acc = 0; cyc = 0; strobes = 0; ready_seen = 0;
        while (acc < k && cyc < 500) begin
            @(negedge clk);
            if (result_64_valid) strobes++;
            if (data_in_valid && data_in_ready) acc++;
            @(posedge clk); #1; cyc++;
            if (acc < k) begin data_in_valid = 1'b1; data_in = $urandom; end
            else data_in_valid = 1'b0;
        end
        enable = 1'b0; data_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (result_64_valid) strobes++;
            if (i > 0) ready_seen |= data_in_ready;
            @(posedge clk); #1;
        end
        chk({tag, "_accepted"}, 64'(acc), 64'(k));
        chk({tag, "_strobes"}, 64'(strobes), 64'(k / n));
        chk({tag, "_bloques"}, 64'(bloques_completos), 64'(k / n));
        chk({tag, "_ready_idle"}, 64'(ready_seen), 64'd0);
        chk({tag, "_not_done"}, 64'(calculo_finalizado), 64'd0);
        $display("abort %s: N=%0d M=%0d samples=%0d strobes=%0d", tag, n, m, k, strobes);
    endtask

    initial begin
        bit any_valid, any_ready;
        reset = 1'b1; enable = 1'b0; data_in = '0; data_in_valid = 1'b0;
        n_muestras = '0; n_bloques = '0; shift = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_r64", result_64, 64'd0);
        chk("rst_r32", 64'(result_32), 64'd0);
        chk("rst_v64", 64'(result_64_valid), 64'd0);
        chk("rst_v32", 64'(result_32_valid), 64'd0);
        chk("rst_ready", 64'(data_in_ready), 64'd0);
        chk("rst_done", 64'(calculo_finalizado), 64'd0);
        chk("rst_bloques", 64'(bloques_completos), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        samp_q = '{10, 20, 30, 40};
        run_blocks("r036", 4, 1, 1, 0);
        chk("r036_r64_const", result_64, 64'd100);
        chk("r036_r32_const", 64'(result_32), 64'd50);

        samp_q = '{-5, -7, -5, -7, -5, -7};
        run_blocks("r037", 2, 3, 0, 40);
        chk("r037_r64_const", result_64, 64'hFFFF_FFFF_FFFF_FFF4);

        samp_q = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        run_blocks("r038", 2, 1, 0, 0);
        chk("r038_r64_const", result_64, 64'h0000_0000_FFFF_FFFE);
`ifdef ACUM_SATURACION_32_EN
        chk("r038_r32_const", 64'(result_32), 64'h7FFF_FFFF);
`else
        chk("r038_r32_const", 64'(result_32), 64'hFFFF_FFFE);
`endif

        abort_run("a039", 8, 1, 3);
        samp_q.delete();
        for (int k = 0; k < 8; k++) samp_q.push_back(int'($urandom_range(0, 1000)) - 500);
        run_blocks("r039", 8, 1, 2, 25);

        abort_run("a_mid", 2, 3, 3);
        abort_run("a_emit", 2, 3, 2);

        // Reset landing on the EMIT cycle.
        enable = 1'b1; n_muestras = 2; n_bloques = 1; shift = 6'd0;
        data_in_valid = 1'b1; data_in = 32'd7;
        @(posedge clk); #1;
        @(posedge clk); #1;
        data_in = 32'd9;
        @(posedge clk); #1;
        chk("emit_pre_v64", 64'(result_64_valid), 64'd1);
        reset = 1'b1; data_in_valid = 1'b0;
        @(negedge clk);
        chk("rst_emit_v64", 64'(result_64_valid), 64'd0);
        chk("rst_emit_v32", 64'(result_32_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_emit_r64", result_64, 64'd0);
        chk("rst_emit_r32", 64'(result_32), 64'd0);
        chk("rst_emit_ready", 64'(data_in_ready), 64'd0);
        chk("rst_emit_bloques", 64'(bloques_completos), 64'd0);
        chk("rst_emit_done", 64'(calculo_finalizado), 64'd0);

        // Leaving reset with enable high but N=0 must stay idle.
        n_muestras = 0; n_bloques = 5;
        @(posedge clk); #1;
        reset = 1'b0; data_in_valid = 1'b1; data_in = 32'd3;
        any_valid = 0; any_ready = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            any_valid |= result_64_valid | result_32_valid;
            any_ready |= data_in_ready;
            @(posedge clk); #1;
        end
        chk("n0_no_strobe", 64'(any_valid), 64'd0);
        chk("n0_no_ready", 64'(any_ready), 64'd0);
        chk("n0_r64", result_64, 64'd0);
        enable = 1'b0; data_in_valid = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < 6; r++) begin
            int rn, rm, rsh;
            rn = $urandom_range(1, 5);
            rm = $urandom_range(1, 3);
            rsh = (r % 2 == 0) ? $urandom_range(0, 8) : $urandom_range(0, 63);
            samp_q.delete();
            for (int k = 0; k < rn * rm; k++) samp_q.push_back(int'($urandom));
            run_blocks($sformatf("rnd%0d", r), rn, rm, rsh, 30);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
